ps2_kbd_matrix: RTL and testbench
=================================

// Module: ps2_kbd_matrix
// PURPOSE
// - Upstream keyboard stage for the LM80C core: receives PS/2 set-2 scancodes and keeps an 8x8 active-low key matrix.
// - The core scans this matrix through PSG port A (row select) and port B (column read).
// - Output km[r][c]=0 while the key mapped to row r, column c is held; 1 when released.
// - Sits between the MiST PS/2 pins and the lm80c KM input; runs on the system clock.
// PARAMETERS
// - FILTER_LEN   8       consecutive equal samples required before the filtered ps2_clk/ps2_data changes
// - TIMEOUT_CYC  50000   sys_clock cycles with no falling ps2_clk edge mid-frame before the receiver aborts
// PORTS
// - sys_clock  in   1     system clock; the only clock
// - reset_n    in   1     asynchronous, active-low reset
// - ps2_clk    in   1     raw PS/2 clock, asynchronous
// - ps2_data   in   1     raw PS/2 data, asynchronous
// - kbd_clear  in   1     synchronous pulse: release all keys (set matrix to all 1s)
// - km         out  8x8   [7:0][7:0] key matrix, index [row][col], active-low
// - frame_err  out  1     1-cycle pulse on a bad start/stop/parity bit or a timeout
// BEHAVIOUR
// - Reset: km=all 8'hFF, frame_err=0, receiver IDLE, decoder NORMAL, skip counter=0, filters at 1.
// - Input conditioning
//   - 2-FF synchroniser on each PS/2 line, then a FILTER_LEN sample filter.
//   - A falling edge is detected on filtered ps2_clk; filtered ps2_data is sampled on that same cycle.
// - Receiver
//   - 11-bit frame: start(0), 8 data bits LSB first, odd parity, stop(1).
//   - A bit counter of 0..10 advances per falling edge.
//   - When bit 10 is sampled, the frame is checked.
//   - Good frame: code_valid pulses for one cycle with an 8-bit code. Bad frame: frame_err pulses and the frame is discarded.
//   - Counter returns to 0 in both cases.
//   - Timeout: if the counter is nonzero and TIMEOUT_CYC cycles pass with no falling edge, frame_err pulses and the counter resets to 0.
// - Decoder FSM (advances only on code_valid)
//   - NORMAL:   E0->EXT, F0->BRK, E1->SKIP(cnt=7), AA->clear matrix, else make(code, ext=0)
//   - EXT:      F0->EXT_BRK, else make(code, ext=1), ->NORMAL
//   - BRK:      break(code, ext=0), ->NORMAL
//   - EXT_BRK:  break(code, ext=1), ->NORMAL
//   - SKIP:     decrement cnt; at 0 ->NORMAL. This swallows the 8-byte Pause sequence.
// - Matrix update
//   - The lookup {ext,code} gives {hit,row[2:0],col[2:0]}.
//   - make clears km[row][col]; break sets it; hit=0 leaves km unchanged.
//   - Latency: km changes 2 sys_clock cycles after the stop-bit falling edge is detected (1 cycle decode, 1 cycle register).
//   - Several scancodes may map to one cell (L/R shift both map to 0x12/0x59 -> row 0, col 0). The last event wins, with no reference counting.
// - Simultaneous events: kbd_clear and a matrix write in the same cycle -> kbd_clear wins.
// - Reset asserted mid-frame discards the partial frame and all decoder state immediately.
// CONFIGURATION
// - Macro KBD_LAST_CODE_EN
//   - When defined, adds two ports:
//     - last_code  out  9  {ext,code} of the last accepted make/break
//     - code_stb   out  1  pulse, coincident with the km update
//   - Both reset to 0. They also fire when hit=0, which lets the bench monitor unmapped keys.
//   - When not defined, neither port exists and nothing else changes.
// STRUCTURE
// - Package lm80c_kbd_pkg:
//   - dec_state_t enum: NORMAL, EXT, BRK, EXT_BRK, SKIP
//   - constants SC_EXT=8'hE0, SC_BRK=8'hF0, SC_PAUSE=8'hE1, SC_BAT=8'hAA
//   - key_pos_t struct: {hit, row[2:0], col[2:0]}
// - Sub-module ps2_kbd_map: purely combinational {ext,code} -> key_pos_t table holding the LM80C layout.
//   - Includes 0x1C(A) -> r2 c1, 0x5A(Enter) -> r7 c0, ext 0x75(Up) -> r6 c3.
// - The receiver, filter and FSM live in this module.
// TESTING
// - Reset, then send frame 0x1C: km[2][1]=0 two cycles after the stop edge; all other bits 1.
// - Send F0,1C: km[2][1] returns to 1. Send E0,75 then E0,F0,75: km[6][3] goes 0 then 1, and km[6][3] is not touched by 0x75 alone.
// - Frame 0x1C sent with even parity: frame_err pulses once and km stays all 8'hFF.
// - Stop after 5 bits and wait TIMEOUT_CYC+10 cycles: frame_err pulses. A following good 0x5A frame gives km[7][0]=0.
// - Hold 0x5A, then send E1,14,77,E1,F0,14,F0,77: only km[7][0]=0 remains. Then AA or kbd_clear gives all 8'hFF.
// - Assert reset_n low during bit 6: km=8'hFF at once, and the next full frame decodes correctly.

Source files
------------

// File: rtl/ps2_kbd_matrix_pkg.sv
// Shared types and scancode constants for the LM80C PS/2 keyboard front end.
package lm80c_kbd_pkg;

  typedef enum logic [2:0] {
    NORMAL  = 3'd0,
    EXT     = 3'd1,
    BRK     = 3'd2,
    EXT_BRK = 3'd3,
    SKIP    = 3'd4
  } dec_state_t;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_PAUSE = 8'hE1;
  localparam logic [7:0] SC_BAT   = 8'hAA;

  typedef struct packed {
    logic       hit;
    logic [2:0] row;
    logic [2:0] col;
  } key_pos_t;

  function automatic key_pos_t kp(input logic [2:0] r, input logic [2:0] c);
    return '{hit: 1'b1, row: r, col: c};
  endfunction

endpackage

// File: rtl/ps2_kbd_map.sv
// Combinational {ext,code} -> matrix cell lookup holding the LM80C keyboard layout.
module ps2_kbd_map
  import lm80c_kbd_pkg::*;
(
  input  logic       ext_i,
  input  logic [7:0] code_i,
  output key_pos_t   pos_o
);

  always_comb begin
    pos_o = '0;
    if (!ext_i) begin
      case (code_i)
        8'h12, 8'h59: pos_o = kp(3'd0, 3'd0);
        8'h14: pos_o = kp(3'd0, 3'd1);  8'h11: pos_o = kp(3'd0, 3'd2);
        8'h58: pos_o = kp(3'd0, 3'd3);  8'h76: pos_o = kp(3'd0, 3'd4);
        8'h0D: pos_o = kp(3'd0, 3'd5);  8'h29: pos_o = kp(3'd0, 3'd6);
        8'h66: pos_o = kp(3'd0, 3'd7);
        8'h16: pos_o = kp(3'd1, 3'd0);  8'h1E: pos_o = kp(3'd1, 3'd1);
        8'h26: pos_o = kp(3'd1, 3'd2);  8'h25: pos_o = kp(3'd1, 3'd3);
        8'h2E: pos_o = kp(3'd1, 3'd4);  8'h36: pos_o = kp(3'd1, 3'd5);
        8'h3D: pos_o = kp(3'd1, 3'd6);  8'h3E: pos_o = kp(3'd1, 3'd7);
        8'h15: pos_o = kp(3'd2, 3'd0);  8'h1C: pos_o = kp(3'd2, 3'd1);
        8'h1A: pos_o = kp(3'd2, 3'd2);  8'h1D: pos_o = kp(3'd2, 3'd3);
        8'h1B: pos_o = kp(3'd2, 3'd4);  8'h22: pos_o = kp(3'd2, 3'd5);
        8'h24: pos_o = kp(3'd2, 3'd6);  8'h23: pos_o = kp(3'd2, 3'd7);
        8'h21: pos_o = kp(3'd3, 3'd0);  8'h2D: pos_o = kp(3'd3, 3'd1);
        8'h2B: pos_o = kp(3'd3, 3'd2);  8'h2A: pos_o = kp(3'd3, 3'd3);
        8'h2C: pos_o = kp(3'd3, 3'd4);  8'h34: pos_o = kp(3'd3, 3'd5);
        8'h32: pos_o = kp(3'd3, 3'd6);  8'h35: pos_o = kp(3'd3, 3'd7);
        8'h33: pos_o = kp(3'd4, 3'd0);  8'h31: pos_o = kp(3'd4, 3'd1);
        8'h3C: pos_o = kp(3'd4, 3'd2);  8'h3B: pos_o = kp(3'd4, 3'd3);
        8'h3A: pos_o = kp(3'd4, 3'd4);  8'h43: pos_o = kp(3'd4, 3'd5);
        8'h42: pos_o = kp(3'd4, 3'd6);  8'h41: pos_o = kp(3'd4, 3'd7);
        8'h44: pos_o = kp(3'd5, 3'd0);  8'h4B: pos_o = kp(3'd5, 3'd1);
        8'h49: pos_o = kp(3'd5, 3'd2);  8'h4D: pos_o = kp(3'd5, 3'd3);
        8'h4C: pos_o = kp(3'd5, 3'd4);  8'h4A: pos_o = kp(3'd5, 3'd5);
        8'h46: pos_o = kp(3'd5, 3'd6);  8'h45: pos_o = kp(3'd5, 3'd7);
        8'h4E: pos_o = kp(3'd6, 3'd0);  8'h55: pos_o = kp(3'd6, 3'd1);
        8'h54: pos_o = kp(3'd6, 3'd2);  8'h5B: pos_o = kp(3'd6, 3'd7);
        8'h5A: pos_o = kp(3'd7, 3'd0);  8'h52: pos_o = kp(3'd7, 3'd1);
        8'h5D: pos_o = kp(3'd7, 3'd2);  8'h0E: pos_o = kp(3'd7, 3'd3);
        8'h05: pos_o = kp(3'd7, 3'd4);  8'h06: pos_o = kp(3'd7, 3'd5);
        8'h04: pos_o = kp(3'd7, 3'd6);  8'h0C: pos_o = kp(3'd7, 3'd7);
        default: pos_o = '0;
      endcase
    end else begin
      // Cursor keys live only in the extended set; plain 0x75 (keypad 8) stays unmapped.
      case (code_i)
        8'h75: pos_o = kp(3'd6, 3'd3);  8'h72: pos_o = kp(3'd6, 3'd4);
        8'h6B: pos_o = kp(3'd6, 3'd5);  8'h74: pos_o = kp(3'd6, 3'd6);
        8'h14: pos_o = kp(3'd0, 3'd1);  8'h11: pos_o = kp(3'd0, 3'd2);
        8'h5A: pos_o = kp(3'd7, 3'd0);
        default: pos_o = '0;
      endcase
    end
  end

endmodule

// File: rtl/ps2_kbd_matrix.sv
// PS/2 set-2 receiver and decoder driving the LM80C 8x8 active-low key matrix; km updates 2 cycles after the stop edge.
// Define KBD_LAST_CODE_EN to add the last_code/code_stb event-monitor ports.
module ps2_kbd_matrix
  import lm80c_kbd_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic            sys_clock,
  input  logic            reset_n,
  input  logic            ps2_clk,
  input  logic            ps2_data,
  input  logic            kbd_clear,
`ifdef KBD_LAST_CODE_EN
  output logic [8:0]      last_code,
  output logic            code_stb,
`endif
  output logic [7:0][7:0] km,
  output logic            frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  // Index 0 is ps2_clk, index 1 is ps2_data.
  logic [1:0]    raw, s1_q, s2_q, filt_q;
  logic [FW-1:0] fcnt_q [2];
  logic          clk_prev_q, fall;

  assign raw  = {ps2_data, ps2_clk};
  assign fall = clk_prev_q & ~filt_q[0];

  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_q       <= '1;
      s2_q       <= '1;
      filt_q     <= '1;
      clk_prev_q <= 1'b1;
      for (int i = 0; i < 2; i++) fcnt_q[i] <= '0;
    end else begin
      s1_q       <= raw;
      s2_q       <= s1_q;
      clk_prev_q <= filt_q[0];
      for (int i = 0; i < 2; i++) begin
        if (s2_q[i] == filt_q[i]) begin
          fcnt_q[i] <= '0;
        end else if (fcnt_q[i] == FW'(FILTER_LEN - 1)) begin
          filt_q[i] <= s2_q[i];
          fcnt_q[i] <= '0;
        end else begin
          fcnt_q[i] <= fcnt_q[i] + 1'b1;
        end
      end
    end
  end

  logic [3:0]    bit_q;
  logic [9:0]    shf_q;
  logic [TW-1:0] to_q;
  logic          code_vld_q, err_q;
  logic [7:0]    code_q;
  logic          frame_ok, timeout;

  // shf_q holds {parity, data[7:0], start} once ten bits have shifted in.
  assign frame_ok = !shf_q[0] && filt_q[1] && (^shf_q[9:1]);
  assign timeout  = (bit_q != 4'd0) && (to_q == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n) begin
      bit_q      <= '0;
      shf_q      <= '0;
      to_q       <= '0;
      code_vld_q <= 1'b0;
      err_q      <= 1'b0;
      code_q     <= '0;
    end else begin
      code_vld_q <= 1'b0;
      err_q      <= 1'b0;
      if (fall) begin
        to_q <= '0;
        if (bit_q == 4'd10) begin
          bit_q <= '0;
          if (frame_ok) begin
            code_vld_q <= 1'b1;
            code_q     <= shf_q[8:1];
          end else begin
            err_q <= 1'b1;
          end
        end else begin
          bit_q <= bit_q + 4'd1;
          shf_q <= {filt_q[1], shf_q[9:1]};
        end
      end else if (timeout) begin
        bit_q <= '0;
        to_q  <= '0;
        err_q <= 1'b1;
      end else if (bit_q != 4'd0) begin
        to_q <= to_q + 1'b1;
      end
    end
  end

  dec_state_t     st_q, st_d;
  logic [2:0]     skip_q, skip_d;
  logic           ev_vld, ev_brk, ev_ext, bat;
  key_pos_t       pos;
  logic [7:0][7:0] km_q;

  always_comb begin
    st_d   = st_q;
    skip_d = skip_q;
    ev_vld = 1'b0;
    ev_brk = 1'b0;
    ev_ext = 1'b0;
    bat    = 1'b0;
    if (code_vld_q) begin
      case (st_q)
        NORMAL: begin
          if (code_q == SC_EXT)        st_d = EXT;
          else if (code_q == SC_BRK)   st_d = BRK;
          else if (code_q == SC_PAUSE) begin
            st_d   = SKIP;
            skip_d = 3'd7;
          end
          else if (code_q == SC_BAT)   bat = 1'b1;
          else                         ev_vld = 1'b1;
        end
        EXT: begin
          ev_ext = 1'b1;
          if (code_q == SC_BRK) st_d = EXT_BRK;
          else begin
            ev_vld = 1'b1;
            st_d   = NORMAL;
          end
        end
        BRK: begin
          ev_vld = 1'b1;
          ev_brk = 1'b1;
          st_d   = NORMAL;
        end
        EXT_BRK: begin
          ev_vld = 1'b1;
          ev_brk = 1'b1;
          ev_ext = 1'b1;
          st_d   = NORMAL;
        end
        SKIP: begin
          skip_d = skip_q - 3'd1;
          if (skip_q == 3'd1) st_d = NORMAL;
        end
        default: st_d = NORMAL;
      endcase
    end
  end

  ps2_kbd_map u_map (
    .ext_i  (ev_ext),
    .code_i (code_q),
    .pos_o  (pos)
  );

  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n) begin
      st_q   <= NORMAL;
      skip_q <= '0;
      km_q   <= '1;
    end else begin
      st_q   <= st_d;
      skip_q <= skip_d;
      if (kbd_clear || bat)       km_q <= '1;
      else if (ev_vld && pos.hit) km_q[pos.row][pos.col] <= ev_brk;
    end
  end

  assign km        = km_q;
  assign frame_err = err_q;

`ifdef KBD_LAST_CODE_EN
  logic [8:0] last_code_q;
  logic       code_stb_q;

  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n) begin
      last_code_q <= '0;
      code_stb_q  <= 1'b0;
    end else begin
      code_stb_q <= ev_vld;
      if (ev_vld) last_code_q <= {ev_ext, code_q};
    end
  end

  assign last_code = last_code_q;
  assign code_stb  = code_stb_q;
`endif

endmodule

// File: tb/tb_ps2_kbd_matrix.sv
// Bench for ps2_kbd_matrix: PS/2 frames driven bit by bit, key matrix checked against an event-level model.
module tb_ps2_kbd_matrix;

  localparam int TO   = 50000;
  localparam int HALF = 16;

  logic            sys_clock = 1'b0;
  logic            reset_n   = 1'b1;
  logic            ps2_clk   = 1'b1;
  logic            ps2_data  = 1'b1;
  logic            kbd_clear = 1'b0;
  logic [7:0][7:0] km;
  logic            frame_err;
`ifdef KBD_LAST_CODE_EN
  logic [8:0]      last_code;
  logic            code_stb;
`endif

  int n_cmp  = 0;
  int n_bad  = 0;
  int n_ferr = 0;
  logic [7:0][7:0] exp_km;

  // The only keys whose matrix position is pinned down independently of the RTL table.
  logic [7:0] key_code [5] = '{8'h1C, 8'h5A, 8'h75, 8'h12, 8'h59};
  logic       key_ext  [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic [2:0] key_row  [5] = '{3'd2, 3'd7, 3'd6, 3'd0, 3'd0};
  logic [2:0] key_col  [5] = '{3'd1, 3'd0, 3'd3, 3'd0, 3'd0};

  ps2_kbd_matrix dut (
    .sys_clock (sys_clock),
    .reset_n   (reset_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .kbd_clear (kbd_clear),
`ifdef KBD_LAST_CODE_EN
    .last_code (last_code),
    .code_stb  (code_stb),
`endif
    .km        (km),
    .frame_err (frame_err)
  );

  always #5 sys_clock = ~sys_clock;

  always @(negedge sys_clock) if (frame_err === 1'b1) n_ferr++;

  task automatic cyc(input int n);
    repeat (n) @(posedge sys_clock);
    #1;
  endtask

  function automatic logic [10:0] frame_of(input logic [7:0] c, input logic bad_par);
    return {1'b1, (~^c) ^ bad_par, c, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = f[i];
      cyc(HALF);
      ps2_clk = 1'b0;
      cyc(HALF);
      ps2_clk = 1'b1;
    end
  endtask

  task automatic send_byte(input logic [7:0] c);
    send_bits(frame_of(c, 1'b0), 11);
    ps2_data = 1'b1;
    cyc(HALF);
  endtask

  // Sends all but the stop bit, then drops ps2_clk for the stop bit and returns right after.
  task automatic send_to_stop_edge(input logic [7:0] c);
    send_bits(frame_of(c, 1'b0), 10);
    ps2_data = 1'b1;
    cyc(HALF);
    ps2_clk = 1'b0;
  endtask

  task automatic test_reset();
    #2 reset_n = 1'b0;
    cyc(3);
    exp_km = '1;
    n_cmp++;
    if (km !== exp_km) begin n_bad++; $display("FAIL reset_km: got %h want %h", km, exp_km); end
    n_cmp++;
    if (frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_ferr: got %b want 0", frame_err); end
    reset_n = 1'b1;
    cyc(5);
  endtask

  task automatic test_make_latency();
    int e0;
    e0 = n_ferr;
    send_to_stop_edge(8'h1C);
    cyc(11);
    n_cmp++;
    if (km !== exp_km) begin n_bad++; $display("FAIL make_early: got %h want %h", km, exp_km); end
    cyc(1);
    exp_km[2][1] = 1'b0;
    n_cmp++;
    if (km !== exp_km) begin n_bad++; $display("FAIL make_1C: got %h want %h", km, exp_km); end
    cyc(HALF - 12);
    ps2_clk = 1'b1;
    cyc(HALF);
    n_cmp++;
    if (n_ferr != e0) begin n_bad++; $display("FAIL make_ferr: got %0d pulses want 0", n_ferr - e0); end
  endtask

  task automatic test_break();
    send_byte(8'hF0);
    send_byte(8'h1C);
    exp_km[2][1] = 1'b1;
    n_cmp++;
    if (km !== exp_km) begin n_bad++; $display("FAIL break_1C: got %h want %h", km, exp_km); end
  endtask

  task automatic test_ext();
    send_byte(8'h75);
    n_cmp++;
    if (km !== exp_km) begin n_bad++; $display("FAIL plain_75: got %h want %h", km, exp_km); end
    send_byte(8'hE0);
    send_byte(8'h75);
    exp_km[6][3] = 1'b0;
    n_cmp++;
    if (km !== exp_km) begin n_bad++; $display("FAIL ext_make_75: got %h want %h", km, exp_km); end
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h75);
    exp_km[6][3] = 1'b1;
    n_cmp++;
    if (km !== exp_km) begin n_bad++; $display("FAIL ext_break_75: got %h want %h", km, exp_km); end
  endtask

  task automatic test_parity();
    int e0;
    e0 = n_ferr;
    send_bits(frame_of(8'h1C, 1'b1), 11);
    ps2_data = 1'b1;
    cyc(HALF);
    n_cmp++;
    if (n_ferr - e0 != 1) begin n_bad++; $display("FAIL parity_ferr: got %0d pulses want 1", n_ferr - e0); end
    n_cmp++;
    if (km !== exp_km) begin n_bad++; $display("FAIL parity_km: got %h want %h", km, exp_km); end
  endtask

  task automatic test_timeout();
    int e0;
    e0 = n_ferr;
    send_bits(frame_of(8'h1C, 1'b0), 5);
    ps2_data = 1'b1;
    cyc(TO + 10);
    n_cmp++;
    if (n_ferr - e0 != 1) begin n_bad++; $display("FAIL timeout_ferr: got %0d pulses want 1", n_ferr - e0); end
    send_byte(8'h5A);
    exp_km[7][0] = 1'b0;
    n_cmp++;
    if (km !== exp_km) begin n_bad++; $display("FAIL after_timeout_5A: got %h want %h", km, exp_km); end
  endtask

  task automatic test_pause();
    logic [7:0] seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    for (int i = 0; i < 8; i++) send_byte(seq[i]);
    n_cmp++;
    if (km !== exp_km) begin n_bad++; $display("FAIL pause_swallow: got %h want %h", km, exp_km); end
    send_byte(8'hAA);
    exp_km = '1;
    n_cmp++;
    if (km !== exp_km) begin n_bad++; $display("FAIL bat_clear: got %h want %h", km, exp_km); end
  endtask

  task automatic test_kbd_clear();
    send_byte(8'h1C);
    kbd_clear = 1'b1;
    cyc(1);
    kbd_clear = 1'b0;
    n_cmp++;
    if (km !== exp_km) begin n_bad++; $display("FAIL kbd_clear: got %h want %h", km, exp_km); end
    // Clear lands on the same edge as the 5A make write.
    send_to_stop_edge(8'h5A);
    cyc(11);
    kbd_clear = 1'b1;
    cyc(1);
    kbd_clear = 1'b0;
    n_cmp++;
    if (km !== exp_km) begin n_bad++; $display("FAIL clear_vs_write: got %h want %h", km, exp_km); end
    cyc(HALF - 12);
    ps2_clk = 1'b1;
    cyc(HALF);
    n_cmp++;
    if (km !== exp_km) begin n_bad++; $display("FAIL clear_vs_write_late: got %h want %h", km, exp_km); end
  endtask

  task automatic test_shift_alias();
    send_byte(8'h12);
    send_byte(8'h59);
    exp_km[0][0] = 1'b0;
    n_cmp++;
    if (km !== exp_km) begin n_bad++; $display("FAIL shift_both_held: got %h want %h", km, exp_km); end
    send_byte(8'hF0);
    send_byte(8'h59);
    exp_km[0][0] = 1'b1;
    n_cmp++;
    if (km !== exp_km) begin n_bad++; $display("FAIL shift_last_wins: got %h want %h", km, exp_km); end
  endtask

  task automatic test_random();
    int k, e0;
    logic brk;
    e0 = n_ferr;
    for (int n = 0; n < 12; n++) begin
      k   = $urandom_range(0, 4);
      brk = 1'($urandom_range(0, 1));
      if (key_ext[k]) send_byte(8'hE0);
      if (brk) send_byte(8'hF0);
      send_byte(key_code[k]);
      exp_km[key_row[k]][key_col[k]] = brk;
      n_cmp++;
      if (km !== exp_km) begin
        n_bad++;
        $display("FAIL random_%0d key %h brk %b: got %h want %h", n, key_code[k], brk, km, exp_km);
      end
    end
    n_cmp++;
    if (n_ferr != e0) begin n_bad++; $display("FAIL random_ferr: got %0d pulses want 0", n_ferr - e0); end
  endtask

  task automatic test_reset_midframe();
    logic [10:0] f;
    send_byte(8'h1C);
    exp_km[2][1] = 1'b0;
    f = frame_of(8'h5A, 1'b0);
    send_bits(f, 6);
    ps2_data = f[6];
    cyc(HALF);
    ps2_clk = 1'b0;
    cyc(4);
    reset_n = 1'b0;
    #1;
    exp_km = '1;
    n_cmp++;
    if (km !== exp_km) begin n_bad++; $display("FAIL midframe_reset_km: got %h want %h", km, exp_km); end
    cyc(2);
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    cyc(2);
    reset_n = 1'b1;
    cyc(HALF);
    send_byte(8'h5A);
    exp_km[7][0] = 1'b0;
    n_cmp++;
    if (km !== exp_km) begin n_bad++; $display("FAIL after_reset_5A: got %h want %h", km, exp_km); end
  endtask

  initial begin
    test_reset();
    test_make_latency();
    test_break();
    test_ext();
    test_parity();
    test_timeout();
    test_pause();
    test_kbd_clear();
    test_shift_alias();
    test_random();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
